uart_loopback_ctrl: RTL and testbench

Sequencing controller for the UART FIFO loopback path. It writes each byte delivered by the UART receiver into the RX FIFO and drops and counts bytes that arrive while the FIFO is full. It drains the FIFO one byte at a time into the UART transmitter through a start/busy/done handshake, with a timeout on the transmitter acknowledge. It sits between `uart_rx`, the RX FIFO and `uart_tx` in the top-level loopback.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_loopback_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_loopback_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } drain_state_t;

    localparam int         DATA_W  = 8;
    localparam logic [7:0] OVF_MAX = 8'hFF;

endpackage

// File: rtl/uart_loopback_ctrl.sv
// Sequences received bytes into the RX FIFO and drains them one at a time into the UART transmitter.
// Latency: rx_done->push 0 cycles; pop->tx_start 1 cycle; 3 cycles per-byte overhead beyond the frame.
// Backpressure: bytes arriving into a full FIFO are dropped and counted; the drain waits on tx_busy/tx_done.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   en                             loopback enable, gates only the drain path
//   rx_done, rx_data               one-cycle byte strobe from the receiver
//   rx_fifo_full/push/wdata        FIFO write side
//   rx_fifo_empty/rdata/pop        FIFO read side (show-ahead data)
//   tx_start, tx_data              transmit request and byte
//   tx_busy, tx_done               transmitter status
//   ovf_clr, ovf_cnt               overflow counter clear / saturating count
//   tx_err                         sticky acknowledge-timeout flag
//   active                         drain FSM is not idle
module uart_loopback_ctrl
    import uart_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_fifo_full,
    output logic              rx_fifo_push,
    output logic [DATA_W-1:0] rx_fifo_wdata,
    input  logic              rx_fifo_empty,
    input  logic [DATA_W-1:0] rx_fifo_rdata,
    output logic              rx_fifo_pop,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              ovf_clr,
    output logic [7:0]        ovf_cnt,
    output logic              tx_err,
    output logic              active
);

    // The timer counts WAIT_ACK cycles starting from 0 on the first one. The
    // abandon decision is taken on the cycle whose increment would reach
    // ACK_TIMEOUT-1, which lands tx_err exactly ACK_TIMEOUT cycles after the
    // tx_start cycle.
    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 2);

    drain_state_t state;
    drain_state_t state_nxt;
    logic [7:0]   timer;
    logic         ack_expired;
    logic         rx_ovf;

    // Receive path: purely combinational, independent of the drain FSM.
    assign rx_fifo_push  = rx_done & ~rx_fifo_full;
    assign rx_fifo_wdata = rx_data;
    assign rx_ovf        = rx_done & rx_fifo_full;

    assign ack_expired = (state == WAIT_ACK) && !tx_busy && (timer == TIMER_LAST);

    always_comb begin
        state_nxt   = state;
        rx_fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (en && !rx_fifo_empty) begin
                    rx_fifo_pop = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_expired) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                // tx_busy is deliberately ignored here; only tx_done ends the byte.
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_start <= 1'b0;
            timer    <= '0;
            tx_err   <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            // A pop always moves IDLE->START, so the registered pop is the start pulse.
            tx_start <= rx_fifo_pop;
            active   <= (state_nxt != IDLE);
            if (rx_fifo_pop) begin
                tx_data <= rx_fifo_rdata;
            end
            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT_ACK && !tx_busy) begin
                timer <= timer + 8'd1;
            end
            if (ack_expired) begin
                tx_err <= 1'b1;
            end
        end
    end

    // Overflow counter: a clear that coincides with a drop still counts that drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= rx_ovf ? 8'd1 : 8'd0;
        end else if (rx_ovf && ovf_cnt != OVF_MAX) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Self-checking bench for uart_loopback_ctrl with a FIFO model and a transmitter model.
// Latency: n/a.
// Backpressure: the transmitter model holds tx_busy for FRAME cycles, or never acknowledges when stuck.
module tb_uart_loopback_ctrl;

    localparam int ACK_TO = 8;
    localparam int FRAME  = 10;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_fifo_full;
    logic       rx_fifo_push;
    logic [7:0] rx_fifo_wdata;
    logic       rx_fifo_empty;
    logic [7:0] rx_fifo_rdata = 8'h00;
    logic       rx_fifo_pop;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] ovf_cnt;
    logic       tx_err;
    logic       active;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    int         fifo_n = 0;
    bit         force_full = 1'b0;
    bit         tx_stuck = 1'b0;
    int         tx_cnt = 0;
    int         n_pop = 0;
    int         n_start = 0;
    int         last_pop = -10;
    int         start_cyc = 0;
    bit         err_prev = 1'b0;

    uart_loopback_ctrl #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rx_done       (rx_done),
        .rx_data       (rx_data),
        .rx_fifo_full  (rx_fifo_full),
        .rx_fifo_push  (rx_fifo_push),
        .rx_fifo_wdata (rx_fifo_wdata),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rdata (rx_fifo_rdata),
        .rx_fifo_pop   (rx_fifo_pop),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .ovf_clr       (ovf_clr),
        .ovf_cnt       (ovf_cnt),
        .tx_err        (tx_err),
        .active        (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_fifo_full  = force_full || (fifo_n >= DEPTH);
    assign rx_fifo_empty = (fifo_n == 0);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // FIFO model: strobes are sampled mid-cycle and applied just after the edge.
    always begin : fifo_model
        logic       s_push;
        logic       s_pop;
        logic [7:0] s_wd;
        @(negedge clk);
        s_push = rx_fifo_push;
        s_pop  = rx_fifo_pop;
        s_wd   = rx_fifo_wdata;
        @(posedge clk);
        #1;
        if (s_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (s_push) fifo_q.push_back(s_wd);
        fifo_n        = fifo_q.size();
        rx_fifo_rdata = (fifo_n != 0) ? fifo_q[0] : 8'h00;
    end

    // Transmitter model.
    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            tx_cnt  <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_cnt != 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
            end
            if (tx_start && !tx_stuck) begin
                tx_busy <= 1'b1;
                tx_cnt  <= FRAME;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_fifo_pop) begin
                n_pop++;
                last_pop = cyc;
                check("pop_while_empty", rx_fifo_empty, 0);
            end
            if (tx_start) begin
                n_start++;
                start_cyc = cyc;
                check("start_latency", cyc, last_pop + 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmission", tx_data);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                end
            end
            if (tx_err && !err_prev) begin
                check("timeout_delay", cyc - start_cyc, ACK_TO);
                check("timeout_active", active, 0);
            end
            err_prev = tx_err;
        end else begin
            err_prev = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_push"}, rx_fifo_push, 0);
        check({tag, "_wdata"}, rx_fifo_wdata, 0);
        check({tag, "_pop"}, rx_fifo_pop, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_ovf_cnt"}, ovf_cnt, 0);
        check({tag, "_tx_err"}, tx_err, 0);
        check({tag, "_active"}, active, 0);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic rx_pulse(input logic [7:0] b, input bit exp_push);
        rx_done = 1'b1;
        rx_data = b;
        if (exp_push) exp_q.push_back(b);
        @(negedge clk);
        check("rx_push", rx_fifo_push, int'(exp_push));
        check("rx_wdata", rx_fifo_wdata, b);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((active || !rx_fifo_empty || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", int'(n < budget), 1);
    endtask

    task automatic wait_high(input string name, input int which, input int budget);
        int  n;
        logic s;
        n = 0;
        s = 1'b0;
        while (!s && n < budget) begin
            @(negedge clk);
            s = (which == 0) ? tx_err : (which == 1) ? tx_busy : tx_start;
            n++;
        end
        check(name, int'(s), 1);
    endtask

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p0;
        int s0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Single byte.
        @(posedge clk);
        #1;
        en = 1'b1;
        rx_pulse(8'hA5, 1'b1);
        @(negedge clk);
        check("single_pop_next_cycle", rx_fifo_pop, 1);
        wait_idle(100);
        check("single_active_low", active, 0);

        // Burst of four bytes while the transmitter is busy.
        @(posedge clk);
        #1;
        p0 = n_pop;
        s0 = n_start;
        for (int i = 1; i <= 4; i++) rx_pulse(8'(i), 1'b1);
        wait_idle(300);
        check("burst_pops", n_pop - p0, 4);
        check("burst_starts", n_start - s0, 4);

        // Overflow with saturation, then clear-with-overflow and clear alone.
        @(posedge clk);
        #1;
        force_full = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rx_pulse(8'(i), 1'b0);
            if (i == 253) check("ovf_254", ovf_cnt, 254);
            if (i == 254) check("ovf_255", ovf_cnt, 255);
        end
        @(negedge clk);
        check("ovf_saturated", ovf_cnt, 255);
        check("ovf_no_push_fifo", fifo_n, 0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        rx_pulse(8'h77, 1'b0);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr_with_drop", ovf_cnt, 1);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr_alone", ovf_cnt, 0);
        force_full = 1'b0;

        // Acknowledge timeout, then the queued byte is popped normally.
        @(posedge clk);
        #1;
        tx_stuck = 1'b1;
        rx_pulse(8'h3C, 1'b1);
        rx_pulse(8'hC3, 1'b1);
        wait_high("timeout_tx_err", 0, 60);
        tx_stuck = 1'b0;
        s0 = n_start;
        wait_idle(200);
        check("timeout_next_byte_started", n_start - s0, 1);
        check("timeout_err_sticky", tx_err, 1);

        // Enable gating.
        @(posedge clk);
        #1;
        en = 1'b0;
        rx_pulse(8'h5A, 1'b1);
        rx_pulse(8'hA6, 1'b1);
        p0 = n_pop;
        s0 = n_start;
        repeat (100) @(negedge clk);
        check("en_low_no_pop", n_pop - p0, 0);
        check("en_low_idle", active, 0);
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_high("en_busy_seen", 1, 20);
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (30) @(negedge clk);
        check("en_drop_one_pop", n_pop - p0, 1);
        check("en_drop_one_start", n_start - s0, 1);
        check("en_drop_finished", active, 0);
        check("en_drop_fifo_left", fifo_n, 1);
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_idle(100);

        // Reset during WAIT_ACK.
        @(posedge clk);
        #1;
        tx_stuck = 1'b1;
        rx_pulse(8'hE7, 1'b1);
        wait_high("rst_start_seen", 2, 20);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_pre_active", active, 1);
        en  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        tx_stuck = 1'b0;
        p0 = n_pop;
        @(posedge clk);
        #1;
        en = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_repop", n_pop - p0, 0);
        check("rst_idle", active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
